// File: rtl/axil_stream_fifo.sv
// AXI4-Lite slave that queues CPU-written words in a FIFO and drains them on an AXI4-Stream master.
// Provides level/status reporting, sticky overflow, flush and a low-watermark refill interrupt.
module axil_stream_fifo #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH_LOG2    = 4,
    parameter int LOWMARK_DEFAULT    = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic                            IRQ
);

    localparam int Depth = 2 ** FIFO_DEPTH_LOG2;
    localparam int LvlW  = FIFO_DEPTH_LOG2 + 1;

    localparam logic [2:0] RegTxData  = 3'd0;
    localparam logic [2:0] RegStatus  = 3'd1;
    localparam logic [2:0] RegControl = 3'd2;
    localparam logic [2:0] RegInfo    = 3'd3;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]            level_q, level_d;
    logic                       overflow_q, overflow_d;
    logic                       out_en_q, out_en_d;
    logic                       irq_en_q, irq_en_d;
    logic [15:0]                lowmark_q, lowmark_d;
    logic                       tvalid_q, tvalid_d;
    logic [31:0]                tdata_q, tdata_d;
    logic                       irq_q, irq_d;

    logic [31:0] mem [Depth];

    logic [2:0]      wr_idx, rd_idx;
    logic            wr_accept, rd_accept;
    logic            push_req, push_ok, pop, flush;
    logic            fifo_full, fifo_empty, below_lowmark;
    logic [15:0]     level_ext;
    logic [LvlW-1:0] level_after_pop;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx    = S_AXI_AWADDR[4:2];
    assign rd_idx    = S_AXI_ARADDR[4:2];
    assign wr_accept = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_accept = arready_q && S_AXI_ARVALID;

    assign fifo_full     = (level_q == LvlW'(Depth));
    assign fifo_empty    = (level_q == '0);
    assign level_ext     = 16'(level_q);
    assign below_lowmark = (level_ext <= lowmark_q);

    // Full is judged on the pre-pop level, so a simultaneous pop never rescues a push into a full FIFO.
    assign push_req = wr_accept && (wr_idx == RegTxData);
    assign push_ok  = push_req && !fifo_full;
    assign flush    = wr_accept && (wr_idx == RegControl) && S_AXI_WDATA[1];
    assign pop      = tvalid_q && M_AXIS_TREADY;

    assign level_after_pop = level_q - LvlW'(pop);

    always_comb begin
        awready_d  = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        overflow_d = overflow_q;
        out_en_d   = out_en_q;
        irq_en_d   = irq_en_q;
        lowmark_d  = lowmark_q;

        if (wr_accept) begin
            bvalid_d = 1'b1;
            bresp_d  = (push_req && fifo_full) ? RespSlvErr : RespOkay;
            if (wr_idx == RegStatus && S_AXI_WDATA[19]) begin
                overflow_d = 1'b0;
            end
            if (wr_idx == RegControl) begin
                out_en_d  = S_AXI_WDATA[0];
                irq_en_d  = S_AXI_WDATA[2];
                lowmark_d = S_AXI_WDATA[31:16];
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        if (rd_accept) begin
            rvalid_d = 1'b1;
            case (rd_idx)
                RegStatus:  rdata_d = {12'h000, overflow_q, below_lowmark, fifo_full, fifo_empty,
                                       level_ext};
                RegControl: rdata_d = {lowmark_q, 13'h0000, irq_en_q, 1'b0, out_en_q};
                RegInfo:    rdata_d = {16'h0000, 16'(Depth)};
                default:    rdata_d = 32'h0000_0000;
            endcase
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A word pushed this cycle is not yet visible, so only already-stored entries can be presented.
        if (!tvalid_q || pop) begin
            tvalid_d = out_en_q && (level_after_pop != '0);
            if (tvalid_d) begin
                tdata_d = mem[rd_ptr_d];
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            tvalid_d = 1'b0;
        end

        irq_d = irq_en_q && below_lowmark;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            out_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            lowmark_q  <= 16'(LOWMARK_DEFAULT);
            tvalid_q   <= 1'b0;
            tdata_q    <= 32'h0000_0000;
            irq_q      <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            out_en_q   <= out_en_d;
            irq_en_q   <= irq_en_d;
            lowmark_q  <= lowmark_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= S_AXI_WDATA;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RespOkay;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign IRQ           = irq_q;

endmodule

// File: tb/tb_axil_stream_fifo.sv
// Directed self-checking bench for axil_stream_fifo (depth 16, lowmark default 4).
module tb_axil_stream_fifo;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] beats[$];
    int          beat_cyc[$];

    axil_stream_fifo #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .FIFO_DEPTH_LOG2   (4),
        .LOWMARK_DEFAULT   (4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (areset),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TREADY(tready),
        .IRQ          (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every stream beat midway through the low phase, after inputs settle and before the edge.
    always begin
        @(negedge clk);
        #2;
        if (tvalid && tready) begin
            beats.push_back(tdata);
            beat_cyc.push_back(cyc);
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input bit pop_on_accept,
                             output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL write_accept_timeout addr=%h: awready never seen, required within 20 cycles", a);
        end
        if (pop_on_accept) tready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (pop_on_accept) tready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL write_resp_timeout addr=%h: bvalid never seen, required within 20 cycles", a);
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL read_accept_timeout addr=%h: arready never seen, required within 20 cycles", a);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL read_resp_timeout addr=%h: rvalid never seen, required within 20 cycles", a);
        end
        d = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, tvalid, tdata, irq}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b br=%b ar=%b r=%b rd=%h tv=%b td=%h irq=%b, required all 0",
                     awready, wready, bvalid, bresp, arready, rvalid, rdata, tvalid, tdata, irq);
        end
        areset = 1'b0;
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0005_0000) begin errors++; $display("FAIL reset_status: got %h required %h", r, 32'h0005_0000); end
        checks++;
        if (rresp !== 2'b00) begin errors++; $display("FAIL rresp_okay: got %b required 00", rresp); end
        axi_read(5'h08, r);
        checks++;
        if (r !== 32'h0004_0000) begin errors++; $display("FAIL reset_control: got %h required %h", r, 32'h0004_0000); end
        axi_read(5'h0C, r);
        checks++;
        if (r !== 32'h0000_0010) begin errors++; $display("FAIL info_depth: got %h required %h", r, 32'h0000_0010); end
    endtask

    task automatic test_push_stream();
        logic [1:0]  resp;
        logic [31:0] r;
        for (int i = 1; i <= 4; i++) begin
            axi_write(5'h00, 32'(i), 1'b0, resp);
            checks++;
            if (resp !== 2'b00) begin errors++; $display("FAIL push%0d_bresp: got %b required 00", i, resp); end
        end
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0004_0004) begin errors++; $display("FAIL status_level4: got %h required %h", r, 32'h0004_0004); end
        checks++;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL tvalid_gated: got %b required 0", tvalid); end
        beats.delete(); beat_cyc.delete();
        tready = 1'b1;
        axi_write(5'h08, 32'h0004_0001, 1'b0, resp);
        repeat (8) @(posedge clk);
        #1 tready = 1'b0;
        checks++;
        if (beats.size() != 4) begin
            errors++; $display("FAIL stream_count: got %0d beats required 4", beats.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beats[i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL stream_beat%0d: got %h required %h", i, beats[i], i + 1);
                end
            end
            checks++;
            if (beat_cyc[3] - beat_cyc[0] != 3) begin
                errors++; $display("FAIL stream_consecutive: got span %0d cycles required 3", beat_cyc[3] - beat_cyc[0]);
            end
        end
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0005_0000) begin errors++; $display("FAIL status_drained: got %h required %h", r, 32'h0005_0000); end
    endtask

    task automatic test_overflow();
        logic [1:0]  resp;
        logic [31:0] r;
        axi_write(5'h08, 32'h0004_0000, 1'b0, resp);
        for (int i = 0; i < 16; i++) begin
            axi_write(5'h00, 32'h100 + 32'(i), 1'b0, resp);
            checks++;
            if (resp !== 2'b00) begin errors++; $display("FAIL fill%0d_bresp: got %b required 00", i, resp); end
        end
        axi_write(5'h00, 32'h0000_0DEAD, 1'b0, resp);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL overflow_bresp: got %b required 10", resp); end
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h000A_0010) begin errors++; $display("FAIL status_full_ovf: got %h required %h", r, 32'h000A_0010); end
        axi_write(5'h04, 32'h0008_0000, 1'b0, resp);
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0002_0010) begin errors++; $display("FAIL ovf_clear: got %h required %h", r, 32'h0002_0010); end
        axi_write(5'h08, 32'h0004_0002, 1'b0, resp);
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0005_0000) begin errors++; $display("FAIL flush_empty: got %h required %h", r, 32'h0005_0000); end
        axi_read(5'h08, r);
        checks++;
        if (r !== 32'h0004_0000) begin errors++; $display("FAIL flush_reads0: got %h required %h", r, 32'h0004_0000); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        for (int i = 0; i < 3; i++) axi_write(5'h00, 32'hA1 + 32'(i), 1'b0, resp);
        beats.delete(); beat_cyc.delete();
        axi_write(5'h08, 32'h0004_0001, 1'b0, resp);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b1 || tdata !== 32'hA1) begin
                errors++; $display("FAIL hold_cycle%0d: got tvalid=%b tdata=%h required 1/%h", i, tvalid, tdata, 32'hA1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tready = (i % 2 == 0);
            @(posedge clk); #1;
        end
        tready = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (beats.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d beats required 3", beats.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[i] !== 32'hA1 + 32'(i)) begin
                    errors++; $display("FAIL bp_beat%0d: got %h required %h", i, beats[i], 32'hA1 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_push_pop();
        logic [1:0]  resp;
        logic [31:0] r;
        axi_write(5'h08, 32'h0004_0000, 1'b0, resp);
        for (int i = 0; i < 5; i++) axi_write(5'h00, 32'hB0 + 32'(i), 1'b0, resp);
        axi_write(5'h08, 32'h0004_0001, 1'b0, resp);
        beats.delete(); beat_cyc.delete();
        axi_write(5'h00, 32'hB5, 1'b1, resp);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL pushpop_bresp: got %b required 00", resp); end
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0000_0005) begin errors++; $display("FAIL pushpop_level: got %h required %h", r, 32'h0000_0005); end
        tready = 1'b1;
        repeat (10) @(posedge clk);
        #1 tready = 1'b0;
        checks++;
        if (beats.size() != 6) begin
            errors++; $display("FAIL pushpop_count: got %0d beats required 6", beats.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (beats[i] !== 32'hB0 + 32'(i)) begin
                    errors++; $display("FAIL pushpop_beat%0d: got %h required %h", i, beats[i], 32'hB0 + 32'(i));
                end
            end
        end
        for (int i = 0; i < 16; i++) axi_write(5'h00, 32'hC0 + 32'(i), 1'b0, resp);
        beats.delete(); beat_cyc.delete();
        axi_write(5'h00, 32'hCF0, 1'b1, resp);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL full_pop_bresp: got %b required 10", resp); end
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0008_000F) begin errors++; $display("FAIL full_pop_status: got %h required %h", r, 32'h0008_000F); end
        tready = 1'b1;
        repeat (20) @(posedge clk);
        #1 tready = 1'b0;
        checks++;
        if (beats.size() != 16) begin
            errors++; $display("FAIL full_pop_count: got %0d beats required 16", beats.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (beats[i] !== 32'hC0 + 32'(i)) begin
                    errors++; $display("FAIL full_pop_beat%0d: got %h required %h", i, beats[i], 32'hC0 + 32'(i));
                end
            end
        end
        axi_write(5'h04, 32'h0008_0000, 1'b0, resp);
    endtask

    task automatic test_irq_flush();
        logic [1:0]  resp;
        logic [31:0] r;
        axi_write(5'h08, 32'h0002_0004, 1'b0, resp);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_empty: got %b required 1", irq); end
        for (int i = 0; i < 4; i++) axi_write(5'h00, 32'hD0 + 32'(i), 1'b0, resp);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_level4: got %b required 0", irq); end
        axi_write(5'h08, 32'h0002_0005, 1'b0, resp);
        tready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        tready = 1'b0;
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b required 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_level2: got %b required 1", irq); end
        axi_write(5'h08, 32'h0002_0004, 1'b0, resp);
        for (int i = 0; i < 8; i++) axi_write(5'h00, 32'hE0 + 32'(i), 1'b0, resp);
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0000_000A) begin errors++; $display("FAIL level10: got %h required %h", r, 32'h0000_000A); end
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'hD2) begin
            errors++; $display("FAIL held_beat: got tvalid=%b tdata=%h required 1/%h", tvalid, tdata, 32'hD2);
        end
        axi_write(5'h08, 32'h0002_0006, 1'b0, resp);
        checks++;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid: got %b required 0", tvalid); end
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0005_0000) begin errors++; $display("FAIL flush_status: got %h required %h", r, 32'h0005_0000); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL flush_irq: got %b required 1", irq); end
    endtask

    task automatic test_reset_midflight();
        logic [1:0]  resp;
        logic [31:0] r;
        int n;
        axi_write(5'h08, 32'h0004_0001, 1'b0, resp);
        for (int i = 0; i < 8; i++) axi_write(5'h00, 32'hF0 + 32'(i), 1'b0, resp);
        @(negedge clk);
        awaddr = 5'h00; wdata = 32'hF8; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || tvalid !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got bvalid=%b tvalid=%b required 1/1", bvalid, tvalid);
        end
        areset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 1'b0 || tvalid !== 1'b0 || irq !== 1'b0 || awready !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got bvalid=%b tvalid=%b irq=%b awready=%b required 0",
                               bvalid, tvalid, irq, awready);
        end
        @(negedge clk);
        areset = 1'b0;
        axi_read(5'h04, r);
        checks++;
        if (r !== 32'h0005_0000) begin errors++; $display("FAIL post_reset_status: got %h required %h", r, 32'h0005_0000); end
        axi_read(5'h08, r);
        checks++;
        if (r !== 32'h0004_0000) begin errors++; $display("FAIL post_reset_control: got %h required %h", r, 32'h0004_0000); end
        axi_read(5'h00, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h required 0", r); end
        axi_write(5'h14, 32'hFFFF_FFFF, 1'b0, resp);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL unmapped_bresp: got %b required 00", resp); end
        axi_read(5'h14, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h required 0", r); end
        checks++;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid: got %b required 0", tvalid); end
    endtask

    initial begin
        test_reset();
        test_push_stream();
        test_overflow();
        test_backpressure();
        test_push_pop();
        test_irq_flush();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
